lsu_hs_stage: RTL and testbench
===============================

// Module: lsu_hs_stage
// PURPOSE
//  Parametrised load/store stage. Successor to the fixed single-cycle execute/memory stage.
//  Takes one memory op per handshake from execute and drives a req/ack data-memory port that
//  tolerates variable latency. Returns an aligned, extended register-write result with error status.
//  Byte lanes scale with DATA_W. Sits between the execute stage and write-back.
// PARAMETERS
//  DATA_W    32  data path width; 32 or 64; lanes NB = DATA_W/8
//  ADDR_W    32  byte address width
//  WAIT_MAX  15  max cycles in S_REQ before a bus timeout; 1..255
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous, active-high reset
//  flush        in   1         kill in-flight op (branch/trap)
//  in_valid     in   1         op present from execute
//  in_ready     out  1         stage can accept (== state S_IDLE)
//  in_we        in   1         1 store, 0 load
//  in_sign      in   1         load sign-extend
//  in_width     in   2         00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//  in_addr      in   ADDR_W    byte address
//  in_wdata     in   DATA_W    store data, right-justified
//  in_rd        in   5         destination register
//  mem_req      out  1         bus request, held until mem_ack
//  mem_we       out  1         bus write
//  mem_addr     out  ADDR_W    lane-aligned address (low log2(NB) bits zero)
//  mem_be       out  NB        byte enables
//  mem_wdata    out  DATA_W    lane-replicated store data
//  mem_ack      in   1         bus completes (rdata valid same cycle)
//  mem_rdata    in   DATA_W    bus read data
//  out_valid    out  1         result present
//  out_ready    in   1         write-back accepts
//  out_rfwe     out  1         register write enable (0 for stores and errors)
//  out_rfwaddr  out  5         = captured in_rd
//  out_rfwdata  out  DATA_W    extended load data, 0 otherwise
//  out_err      out  2         00 ok, 01 misaligned, 10 bus timeout
// BEHAVIOUR
//  - Reset: state S_IDLE. Registered outputs (mem_req, mem_we, mem_addr, mem_be, mem_wdata,
//    out_valid, out_rfwe, out_rfwaddr, out_rfwdata, out_err) and the wait counter are 0.
//  - FSM: S_IDLE -(in_valid)-> S_REQ; S_REQ -(mem_ack | timeout)-> S_RESP;
//    S_RESP -(out_ready)-> S_IDLE. No back-to-back accept from S_RESP.
//  - Latency: op accepted at edge N -> mem_req=1 from N+1. mem_ack at cycle M -> out_valid=1 from M+1.
//  - Outputs are stable while mem_req&!mem_ack and while out_valid&!out_ready.
//  - Lanes: off = addr[log2(NB)-1:0]; mem_be = ((1<<(1<<width))-1) << off.
//    mem_wdata = in_wdata low (8<<width) bits replicated across DATA_W.
//  - Load: d = mem_rdata >> (off*8); take low (8<<width) bits; sign-extend if in_sign, else zero-extend.
//    Full-width loads ignore in_sign.
//  - Timeout: the counter runs only in S_REQ and clears on entry. At WAIT_MAX cycles without mem_ack:
//    mem_req drops, out_err=10, out_rfwe=0, go to S_RESP. A late mem_ack arriving outside S_REQ is ignored.
//  - mem_ack and the timeout in the same cycle: ack wins, out_err=00.
//  - flush: S_IDLE no effect, in_ready unaffected. S_REQ: bus transaction completes normally;
//    on ack/timeout return to S_IDLE with no out_valid. S_RESP: out_valid drops next cycle, go S_IDLE.
//    flush has priority over out_ready in the same cycle.
//  - in_width=11 with DATA_W=32 is treated as misaligned.
//  - rst asserted mid-transaction: immediate return to reset values; the bus must tolerate a dropped req.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: an address not a multiple of (1<<width) issues no mem_req.
//    Next cycle S_RESP, out_err=01, out_rfwe=0, out_rfwdata=0.
//  LSU_MISALIGN_TRAP_EN undefined: low width bits of addr are forced to 0 (natural alignment).
//    The access proceeds and out_err never reports 01.
// TESTING
//  1 rst=1 async mid-cycle -> all outputs 0 immediately; after release in_ready=1.
//  2 DATA_W=32, lb addr=0x103, rdata=0x80FF_FF00, sign=1, ack after 3 cycles
//    -> mem_addr=0x100, be=1000, out_rfwdata=0xFFFF_FF80, out_rfwe=1.
//  3 sh addr=0x202, wdata=0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, out_rfwe=0.
//  4 lw with no ack, WAIT_MAX=15 -> mem_req drops after 15 cycles, out_err=10.
//    A later ack is ignored.
//  5 lw addr=0x101: with LSU_MISALIGN_TRAP_EN -> no mem_req, out_err=01.
//    Without it -> mem_addr=0x100, be=1111, out_err=00.
//  6 flush during S_REQ, ack 2 cycles later -> no out_valid. out_ready=0 stall in S_RESP
//    holds all out_* stable for 5 cycles.

Source files
------------

// File: rtl/lsu_hs_stage.sv
// Load/store stage: one op per handshake, req/ack data port with timeout, aligned extended result.
// Define LSU_MISALIGN_TRAP_EN to report misaligned ops as errors instead of forcing natural alignment.
module lsu_hs_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic              in_sign,
    input  logic [1:0]        in_width,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rfwe,
    output logic [4:0]        out_rfwaddr,
    output logic [DATA_W-1:0] out_rfwdata,
    output logic [1:0]        out_err
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                flushed_q, flushed_d;
    logic                we_q, we_d;
    logic                sign_q, sign_d;
    logic [1:0]          width_q, width_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic [4:0]          rd_q, rd_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]       mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic                out_rfwe_q, out_rfwe_d;
    logic [4:0]          out_rfwaddr_q, out_rfwaddr_d;
    logic [DATA_W-1:0]   out_rfwdata_q, out_rfwdata_d;
    logic [1:0]          out_err_q, out_err_d;

    logic [1:0]          w_eff;
    logic                bad_w;
    logic                misal;
    logic [3:0]          bytes_n;
    logic [ADDR_W-1:0]   amask;
    logic [ADDR_W-1:0]   a_al;
    logic [OFFW-1:0]     off;
    logic [NB-1:0]       be_n;
    logic [DATA_W-1:0]   wd_n;
    logic                timeout;

    // Request-side lane decode from the incoming op
    always_comb begin
        bad_w = (DATA_W == 32) && (in_width == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        w_eff   = in_width;
        bytes_n = 4'd1 << w_eff;
        amask   = ADDR_W'(bytes_n - 4'd1);
        misal   = bad_w || ((in_addr & amask) != '0);
        a_al    = in_addr;
`else
        w_eff   = bad_w ? 2'b10 : in_width;
        bytes_n = 4'd1 << w_eff;
        amask   = ADDR_W'(bytes_n - 4'd1);
        misal   = 1'b0;
        a_al    = in_addr & ~amask;
`endif
        off  = a_al[OFFW-1:0];
        be_n = '0;
        wd_n = '0;
        for (int i = 0; i < NB; i++) begin
            be_n[i] = (i >= int'(off)) && (i < int'(off) + int'(bytes_n));
            wd_n[i*8 +: 8] = in_wdata[(i % int'(bytes_n))*8 +: 8];
        end
    end

    logic [DATA_W-1:0]   sh_r;
    logic [DATA_W-1:0]   ext;
    logic [3:0]          nb_r;
    logic                sbit;
    int                  sidx;

    // Load-side shift and extension using the captured op
    always_comb begin
        sh_r = mem_rdata >> {off_q, 3'b000};
        nb_r = 4'd1 << width_q;
        sidx = int'(nb_r) * 8 - 1;
        sbit = 1'b0;
        if (sidx < DATA_W) sbit = sign_q & sh_r[sidx];
        ext = '0;
        for (int i = 0; i < NB; i++) begin
            ext[i*8 +: 8] = (i < int'(nb_r)) ? sh_r[i*8 +: 8] : {8{sbit}};
        end
    end

    assign timeout = (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flushed_d     = flushed_q;
        we_d          = we_q;
        sign_d        = sign_q;
        width_d       = width_q;
        off_d         = off_q;
        rd_d          = rd_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        out_valid_d   = out_valid_q;
        out_rfwe_d    = out_rfwe_q;
        out_rfwaddr_d = out_rfwaddr_q;
        out_rfwdata_d = out_rfwdata_q;
        out_err_d     = out_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    we_d      = in_we;
                    sign_d    = in_sign;
                    width_d   = w_eff;
                    off_d     = off;
                    rd_d      = in_rd;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                    if (misal) begin
                        state_d       = S_RESP;
                        out_valid_d   = 1'b1;
                        out_rfwe_d    = 1'b0;
                        out_rfwaddr_d = in_rd;
                        out_rfwdata_d = '0;
                        out_err_d     = 2'b01;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_we;
                        mem_addr_d  = {a_al[ADDR_W-1:OFFW], OFFW'(0)};
                        mem_be_d    = be_n;
                        mem_wdata_d = wd_n;
                    end
                end
            end
            S_REQ: begin
                if (flush) flushed_d = 1'b1;
                if (mem_ack || timeout) begin
                    mem_req_d = 1'b0;
                    if (flushed_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d       = S_RESP;
                        out_valid_d   = 1'b1;
                        out_rfwaddr_d = rd_q;
                        out_err_d     = mem_ack ? 2'b00 : 2'b10;
                        out_rfwe_d    = mem_ack && !we_q;
                        out_rfwdata_d = (mem_ack && !we_q) ? ext : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (flush || out_ready) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b0;
                    out_rfwe_d    = 1'b0;
                    out_rfwaddr_d = '0;
                    out_rfwdata_d = '0;
                    out_err_d     = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            flushed_q     <= 1'b0;
            we_q          <= 1'b0;
            sign_q        <= 1'b0;
            width_q       <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            out_valid_q   <= 1'b0;
            out_rfwe_q    <= 1'b0;
            out_rfwaddr_q <= '0;
            out_rfwdata_q <= '0;
            out_err_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flushed_q     <= flushed_d;
            we_q          <= we_d;
            sign_q        <= sign_d;
            width_q       <= width_d;
            off_q         <= off_d;
            rd_q          <= rd_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            out_valid_q   <= out_valid_d;
            out_rfwe_q    <= out_rfwe_d;
            out_rfwaddr_q <= out_rfwaddr_d;
            out_rfwdata_q <= out_rfwdata_d;
            out_err_q     <= out_err_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign out_valid   = out_valid_q;
    assign out_rfwe    = out_rfwe_q;
    assign out_rfwaddr = out_rfwaddr_q;
    assign out_rfwdata = out_rfwdata_q;
    assign out_err     = out_err_q;

endmodule

// File: tb/tb_lsu_hs_stage.sv
// Directed bench for lsu_hs_stage (DATA_W=32, WAIT_MAX=15).
// Vector table for single ops plus hand sequences for timeout, flush, stall and reset.
module tb_lsu_hs_stage;
    logic        clk, rst, flush;
    logic        in_valid, in_ready, in_we, in_sign;
    logic [1:0]  in_width;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, out_ready, out_rfwe;
    logic [4:0]  out_rfwaddr;
    logic [31:0] out_rfwdata;
    logic [1:0]  out_err;

    int checks = 0;
    int errors = 0;

    lsu_hs_stage #(.DATA_W(32), .ADDR_W(32), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_sign(in_sign), .in_width(in_width), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_rfwe(out_rfwe), .out_rfwaddr(out_rfwaddr),
        .out_rfwdata(out_rfwdata), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        sign;
        logic [1:0]  w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        erfwe;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic sg, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_we = we; in_sign = sg; in_width = w;
        in_addr = a; in_wdata = wd; in_rd = rd;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        mem_ack = 1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 0;
    endtask

    task automatic retire();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        vt[0] = '{0, 1, 2'b00, 32'h103, 32'h0,        32'h80FF_FF00, 3, 32'h100, 4'b1000, 32'h0,        1, 32'hFFFF_FF80};
        vt[1] = '{1, 0, 2'b01, 32'h202, 32'h1234_ABCD, 32'h0,        1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 32'h0};
        vt[2] = '{0, 0, 2'b01, 32'h102, 32'h0,        32'h80FF_FF00, 0, 32'h100, 4'b1100, 32'h0,        1, 32'h0000_80FF};
        vt[3] = '{0, 1, 2'b01, 32'h100, 32'h0,        32'h1234_8001, 2, 32'h100, 4'b0011, 32'h0,        1, 32'hFFFF_8001};
        vt[4] = '{0, 1, 2'b10, 32'h104, 32'h0,        32'hDEAD_BEEF, 1, 32'h104, 4'b1111, 32'h0,        1, 32'hDEAD_BEEF};
        vt[5] = '{1, 0, 2'b00, 32'h101, 32'h0000_005A, 32'h0,        0, 32'h100, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0};
        vt[6] = '{0, 0, 2'b00, 32'h102, 32'h0,        32'h00A5_0000, 2, 32'h100, 4'b0100, 32'h0,        1, 32'h0000_00A5};
        vt[7] = '{1, 0, 2'b10, 32'h10C, 32'hCAFE_BABE, 32'h0,        1, 32'h10C, 4'b1111, 32'hCAFE_BABE, 0, 32'h0};

        rst = 1; flush = 0; in_valid = 0; in_we = 0; in_sign = 0; in_width = 0;
        in_addr = 0; in_wdata = 0; in_rd = 0; mem_ack = 0; mem_rdata = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_out_rfwdata", out_rfwdata, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            issue(vt[i].we, vt[i].sign, vt[i].w, vt[i].addr, vt[i].wdata, 5'(i + 1));
            chk("v_mem_req", mem_req, 1);
            chk("v_in_ready_busy", in_ready, 0);
            chk("v_mem_we", mem_we, vt[i].we);
            chk("v_mem_addr", mem_addr, vt[i].eaddr);
            chk("v_mem_be", mem_be, vt[i].ebe);
            if (vt[i].we) chk("v_mem_wdata", mem_wdata, vt[i].ewd);
            for (int k = 0; k < vt[i].dly; k++) begin
                @(negedge clk);
                chk("v_req_hold", {mem_req, mem_be, mem_addr}, {1'b1, vt[i].ebe, vt[i].eaddr});
            end
            ack_now(vt[i].rdata);
            chk("v_req_drop", mem_req, 0);
            chk("v_out_valid", out_valid, 1);
            chk("v_out_rfwe", out_rfwe, vt[i].erfwe);
            chk("v_out_rfwaddr", out_rfwaddr, 5'(i + 1));
            chk("v_out_rfwdata", out_rfwdata, vt[i].erd);
            chk("v_out_err", out_err, 0);
            retire();
        end

        // bus timeout, then late acks ignored
        issue(0, 0, 2'b10, 32'h100, 32'h0, 5'd9);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("to_req_hold", mem_req, 1);
        end
        @(negedge clk);
        chk("to_req_drop", mem_req, 0);
        chk("to_out_valid", out_valid, 1);
        chk("to_err", out_err, 2'b10);
        chk("to_rfwe", out_rfwe, 0);
        ack_now(32'h1111_1111);
        chk("to_late_ack_err", out_err, 2'b10);
        chk("to_late_ack_valid", out_valid, 1);
        retire();
        ack_now(32'h2222_2222);
        chk("idle_ack_valid", out_valid, 0);
        chk("idle_ack_ready", in_ready, 1);

        // ack in the same cycle as the timeout: ack wins
        issue(0, 0, 2'b10, 32'h100, 32'h0, 5'd10);
        repeat (14) @(negedge clk);
        chk("race_req", mem_req, 1);
        ack_now(32'h0BAD_F00D);
        chk("race_valid", out_valid, 1);
        chk("race_err", out_err, 0);
        chk("race_data", out_rfwdata, 32'h0BAD_F00D);
        retire();

        // misaligned word
        issue(0, 0, 2'b10, 32'h101, 32'h0, 5'd11);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_no_req", mem_req, 0);
        chk("mis_valid", out_valid, 1);
        chk("mis_err", out_err, 2'b01);
        chk("mis_rfwe", out_rfwe, 0);
        chk("mis_rfwdata", out_rfwdata, 0);
`else
        chk("mis_req", mem_req, 1);
        chk("mis_addr", mem_addr, 32'h100);
        chk("mis_be", mem_be, 4'b1111);
        ack_now(32'h7654_3210);
        chk("mis_err", out_err, 0);
        chk("mis_rfwdata", out_rfwdata, 32'h7654_3210);
`endif
        retire();

        // flush during request; ack two cycles later gives no result
        issue(0, 0, 2'b10, 32'h200, 32'h0, 5'd12);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("fl_req_hold", mem_req, 1);
        @(negedge clk);
        ack_now(32'h5555_5555);
        chk("fl_no_valid", out_valid, 0);
        chk("fl_idle", in_ready, 1);

        // stall in response holds outputs, then flush beats out_ready
        issue(0, 1, 2'b00, 32'h301, 32'h0, 5'd13);
        ack_now(32'h0000_F000);
        for (int k = 0; k < 5; k++) begin
            chk("st_hold", {out_valid, out_rfwe, out_rfwaddr, out_rfwdata, out_err},
                {1'b1, 1'b1, 5'd13, 32'hFFFF_FFF0, 2'b00});
            @(negedge clk);
        end
        flush = 1; out_ready = 1;
        @(negedge clk);
        flush = 0; out_ready = 0;
        chk("st_flush_drop", out_valid, 0);
        chk("st_flush_idle", in_ready, 1);

        // async reset in the middle of a request
        issue(1, 0, 2'b10, 32'h400, 32'hFFFF_FFFF, 5'd14);
        chk("ar_req", mem_req, 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("ar_req_drop", mem_req, 0);
        chk("ar_be_zero", mem_be, 0);
        chk("ar_wdata_zero", mem_wdata, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("ar_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
